// File: rtl/idma_desc_queue_pkg.sv
// Shared definitions for the iDMA descriptor queue frontend: register map,
// bit indices and the descriptor payload carried through the queue.
package idma_desc_queue_pkg;

  localparam int unsigned RegWidth  = 64;
  localparam int unsigned OffWidth  = 7;
  localparam int unsigned FieldMax  = 64;

  localparam logic [OffWidth-1:0] OffSrc      = 7'h00;
  localparam logic [OffWidth-1:0] OffDst      = 7'h08;
  localparam logic [OffWidth-1:0] OffNumBytes = 7'h10;
  localparam logic [OffWidth-1:0] OffConf     = 7'h18;
  localparam logic [OffWidth-1:0] OffStatus   = 7'h20;
  localparam logic [OffWidth-1:0] OffSubmit   = 7'h28;
  localparam logic [OffWidth-1:0] OffDoneId   = 7'h30;
  localparam logic [OffWidth-1:0] OffIp       = 7'h38;
  localparam logic [OffWidth-1:0] OffIe       = 7'h40;

  localparam int unsigned ConfDecoupleBit = 0;
  localparam int unsigned ConfDeburstBit  = 1;
  localparam int unsigned IpDoneBit       = 0;
  localparam int unsigned IpErrBit        = 1;

  // Fields held at full register width; the frontend truncates on the way out.
  typedef struct packed {
    logic [FieldMax-1:0] src;
    logic [FieldMax-1:0] dst;
    logic [FieldMax-1:0] len;
    logic [FieldMax-1:0] id;
    logic                decouple;
    logic                deburst;
  } desc_t;

endpackage

// File: rtl/idma_desc_fifo.sv
// Power-of-two circular FIFO for descriptors; push ignored when full,
// pop ignored when empty, both allowed in the same cycle.
module idma_desc_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         T     = logic
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  T                    mem_q [Depth];
  logic [PtrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == CntWidth'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PtrWidth'(1);
    if (do_pop)  rptr_d = rptr_q + PtrWidth'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/idma_desc_queue_frontend.sv
// Register-programmed descriptor queue feeding an iDMA backend, with transfer
// ID allocation, completion tracking and a level interrupt.
module idma_desc_queue_frontend
  import idma_desc_queue_pkg::*;
#(
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned LenWidth   = 32,
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned IdWidth    = 32,
  parameter logic [3:0]  DeviceId   = 4'd1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_valid_i,
  input  logic                 reg_write_i,
  input  logic [OffWidth-1:0]  reg_addr_i,
  input  logic [RegWidth-1:0]  reg_wdata_i,
  output logic [RegWidth-1:0]  reg_rdata_o,
  output logic                 reg_error_o,
  output logic [AddrWidth-1:0] src_addr_o,
  output logic [AddrWidth-1:0] dst_addr_o,
  output logic [LenWidth-1:0]  length_o,
  output logic                 decouple_o,
  output logic                 deburst_o,
  output logic [3:0]           axi_id_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  input  logic                 trans_complete_i,
  output logic                 irq_o
);

  localparam int unsigned CntWidth = $clog2(QueueDepth) + 1;

  logic [AddrWidth-1:0] src_q, src_d, dst_q, dst_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [1:0]           conf_q, conf_d, ie_q, ie_d, ip_q, ip_d, ip_set, ip_clr;
  logic [IdWidth-1:0]   next_id_q, next_id_d, done_id_q, done_id_d, outst_q, outst_d;

  logic                 acc, rd, wr, push, pop, tc_ok, tc_bad, busy, dec_err;
  logic [RegWidth-1:0]  rdata_mux;
  logic                 fifo_full, fifo_empty;
  logic [CntWidth-1:0]  fifo_count;
  desc_t                push_desc, head;
  logic                 unused_c;

  // IDs skip zero so that 0 can mean "nothing accepted".
  function automatic logic [IdWidth-1:0] id_inc(input logic [IdWidth-1:0] v);
    return (v == '1) ? IdWidth'(1) : v + IdWidth'(1);
  endfunction

  assign acc  = reg_valid_i & ~rst_i;
  assign rd   = acc & ~reg_write_i;
  assign wr   = acc & reg_write_i;
  assign push = rd & (reg_addr_i == OffSubmit) & (len_q != '0) & ~fifo_full;
  assign pop  = valid_o & ready_i;
  // A completion is legal if something is outstanding or retiring this cycle.
  assign tc_ok  = trans_complete_i & ((outst_q != '0) | pop);
  assign tc_bad = trans_complete_i & ~tc_ok;
  assign busy   = ~fifo_empty | (outst_q != '0);

  always_comb begin
    push_desc          = '0;
    push_desc.src      = FieldMax'(src_q);
    push_desc.dst      = FieldMax'(dst_q);
    push_desc.len      = FieldMax'(len_q);
    push_desc.id       = FieldMax'(next_id_q);
    push_desc.decouple = conf_q[ConfDecoupleBit];
    push_desc.deburst  = conf_q[ConfDeburstBit];
  end

  idma_desc_fifo #(
    .Depth (QueueDepth),
    .T     (desc_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_desc),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rdata_mux = '0;
    dec_err   = 1'b0;
    case (reg_addr_i)
      OffSrc:      rdata_mux = RegWidth'(src_q);
      OffDst:      rdata_mux = RegWidth'(dst_q);
      OffNumBytes: rdata_mux = RegWidth'(len_q);
      OffConf:     rdata_mux = RegWidth'(conf_q);
      OffStatus:   rdata_mux = RegWidth'({fifo_full, 8'(fifo_count), 7'b0, busy});
      OffSubmit:   rdata_mux = push ? RegWidth'(next_id_q) : '0;
      OffDoneId:   rdata_mux = RegWidth'(done_id_q);
      OffIp:       rdata_mux = RegWidth'(ip_q);
      OffIe:       rdata_mux = RegWidth'(ie_q);
      default:     dec_err   = 1'b1;
    endcase
  end

  assign reg_rdata_o = (rd & ~dec_err) ? rdata_mux : '0;
  assign reg_error_o = acc & dec_err;

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    conf_d = conf_q;
    ie_d   = ie_q;
    ip_clr = '0;
    if (wr) begin
      case (reg_addr_i)
        OffSrc:      src_d  = reg_wdata_i[AddrWidth-1:0];
        OffDst:      dst_d  = reg_wdata_i[AddrWidth-1:0];
        OffNumBytes: len_d  = reg_wdata_i[LenWidth-1:0];
        OffConf:     conf_d = reg_wdata_i[1:0];
        OffIp:       ip_clr = reg_wdata_i[1:0];
        OffIe:       ie_d   = reg_wdata_i[1:0];
        default:     ;
      endcase
    end
    ip_set            = '0;
    ip_set[IpDoneBit] = tc_ok;
    ip_set[IpErrBit]  = tc_bad;
    ip_d      = (ip_q & ~ip_clr) | ip_set;
    next_id_d = push ? id_inc(next_id_q) : next_id_q;
    done_id_d = tc_ok ? id_inc(done_id_q) : done_id_q;
    case ({pop, tc_ok})
      2'b10:   outst_d = outst_q + IdWidth'(1);
      2'b01:   outst_d = outst_q - IdWidth'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      conf_q    <= '0;
      ie_q      <= '0;
      ip_q      <= '0;
      outst_q   <= '0;
      next_id_q <= IdWidth'(1);
      done_id_q <= '0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      conf_q    <= conf_d;
      ie_q      <= ie_d;
      ip_q      <= ip_d;
      outst_q   <= outst_d;
      next_id_q <= next_id_d;
      done_id_q <= done_id_d;
    end
  end

  // Backend data is forced to zero whenever no descriptor is presented.
  assign valid_o    = ~fifo_empty & ~rst_i;
  assign src_addr_o = valid_o ? AddrWidth'(head.src) : '0;
  assign dst_addr_o = valid_o ? AddrWidth'(head.dst) : '0;
  assign length_o   = valid_o ? LenWidth'(head.len) : '0;
  assign decouple_o = valid_o & head.decouple;
  assign deburst_o  = valid_o & head.deburst;
  assign axi_id_o   = DeviceId;
  assign irq_o      = |(ip_q & ie_q);
  assign unused_c   = ^head;

endmodule

// File: tb/tb_idma_desc_queue_frontend.sv
// Directed bench for the descriptor queue frontend with hand-computed expectations.
module tb_idma_desc_queue_frontend;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        reg_valid_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [6:0]  reg_addr_i  = '0;
  logic [63:0] reg_wdata_i = '0;
  logic [63:0] reg_rdata_o;
  logic        reg_error_o;
  logic [63:0] src_addr_o, dst_addr_o;
  logic [31:0] length_o;
  logic        decouple_o, deburst_o, valid_o, irq_o;
  logic [3:0]  axi_id_o;
  logic        ready_i = 1'b0;
  logic        trans_complete_i = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_miscmp = 0;
  logic [63:0] d;
  logic        e;

  localparam logic [6:0] A_SRC = 7'h00, A_DST = 7'h08, A_NUM = 7'h10, A_CONF = 7'h18,
                         A_STAT = 7'h20, A_SUB = 7'h28, A_DONE = 7'h30, A_IP = 7'h38,
                         A_IE = 7'h40;

  idma_desc_queue_frontend dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .reg_valid_i      (reg_valid_i),
    .reg_write_i      (reg_write_i),
    .reg_addr_i       (reg_addr_i),
    .reg_wdata_i      (reg_wdata_i),
    .reg_rdata_o      (reg_rdata_o),
    .reg_error_o      (reg_error_o),
    .src_addr_o       (src_addr_o),
    .dst_addr_o       (dst_addr_o),
    .length_o         (length_o),
    .decouple_o       (decouple_o),
    .deburst_o        (deburst_o),
    .axi_id_o         (axi_id_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .trans_complete_i (trans_complete_i),
    .irq_o            (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One register access in a single cycle; optional completion pulse alongside.
  task automatic reg_acc(input logic wrt, input logic [6:0] addr, input logic [63:0] wdata,
                         input logic tc, output logic [63:0] rdata, output logic err);
    @(negedge clk_i);
    reg_valid_i = 1'b1;
    reg_write_i = wrt;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    trans_complete_i = tc;
    #1;
    rdata = reg_rdata_o;
    err   = reg_error_o;
    @(posedge clk_i);
    #1;
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
    trans_complete_i = 1'b0;
  endtask

  task automatic rd(input logic [6:0] addr, output logic [63:0] rdata);
    logic err;
    reg_acc(1'b0, addr, 64'h0, 1'b0, rdata, err);
  endtask

  task automatic wr(input logic [6:0] addr, input logic [63:0] wdata);
    logic [63:0] rdata;
    logic err;
    reg_acc(1'b1, addr, wdata, 1'b0, rdata, err);
  endtask

  task automatic tc_pulse();
    @(negedge clk_i);
    trans_complete_i = 1'b1;
    @(posedge clk_i);
    #1;
    trans_complete_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_valid", 64'(valid_o), 64'h0);
    check("rst_irq", 64'(irq_o), 64'h0);
    check("rst_src", src_addr_o, 64'h0);
    check("rst_axi_id", 64'(axi_id_o), 64'h1);
    rd(A_STAT, d); check("rst_status", d, 64'h0);

    // Zero-length submit is rejected and consumes no ID.
    rd(A_SUB, d); check("zero_len_submit", d, 64'h0);
    check("zero_len_valid", 64'(valid_o), 64'h0);

    ready_i = 1'b1;
    wr(A_SRC, 64'h1000);
    wr(A_DST, 64'h2000);
    wr(A_NUM, 64'd64);
    rd(A_SUB, d); check("first_submit_id", d, 64'h1);
    check("first_valid", 64'(valid_o), 64'h1);
    check("first_len", 64'(length_o), 64'd64);
    check("first_src", src_addr_o, 64'h1000);
    check("first_dst", dst_addr_o, 64'h2000);
    @(posedge clk_i); #1;
    check("first_popped", 64'(valid_o), 64'h0);
    rd(A_STAT, d); check("outstanding_busy", d, 64'h1);
    tc_pulse();
    rd(A_DONE, d); check("done_id_1", d, 64'h1);
    rd(A_IP, d); check("ip_done_set", d, 64'h1);
    check("irq_masked", 64'(irq_o), 64'h0);

    // Two more transfers issued and completed with the done interrupt enabled.
    wr(A_IP, 64'h3);
    rd(A_IP, d); check("ip_cleared", d, 64'h0);
    wr(A_IE, 64'h1);
    check("irq_ie_only", 64'(irq_o), 64'h0);
    rd(A_SUB, d); check("submit_id_2", d, 64'h2);
    rd(A_SUB, d); check("submit_id_3", d, 64'h3);
    tc_pulse();
    tc_pulse();
    rd(A_DONE, d); check("done_id_3", d, 64'h3);
    check("irq_done", 64'(irq_o), 64'h1);
    wr(A_IP, 64'h1);
    check("irq_after_w1c", 64'(irq_o), 64'h0);
    rd(A_STAT, d); check("idle_status", d, 64'h0);

    // Spurious completion, then W1C of err racing a new spurious pulse.
    tc_pulse();
    rd(A_IP, d); check("ip_err_set", d, 64'h2);
    rd(A_DONE, d); check("done_id_unchanged", d, 64'h3);
    check("irq_err_masked", 64'(irq_o), 64'h0);
    reg_acc(1'b1, A_IP, 64'h2, 1'b1, d, e);
    rd(A_IP, d); check("err_set_wins", d, 64'h2);
    wr(A_IE, 64'h3);
    check("irq_err", 64'(irq_o), 64'h1);
    wr(A_IP, 64'h3);

    // Fill the queue with the backend stalled.
    ready_i = 1'b0;
    wr(A_NUM, 64'd16);
    rd(A_SUB, d); check("fill_id_4", d, 64'h4);
    rd(A_SUB, d); check("fill_id_5", d, 64'h5);
    rd(A_SUB, d); check("fill_id_6", d, 64'h6);
    rd(A_SUB, d); check("fill_id_7", d, 64'h7);
    rd(A_SUB, d); check("full_submit", d, 64'h0);
    rd(A_STAT, d); check("full_status", d, 64'h10401);
    check("full_valid", 64'(valid_o), 64'h1);
    check("full_head_len", 64'(length_o), 64'd16);
    ready_i = 1'b1;
    rd(A_SUB, d); check("full_with_pop", d, 64'h0);
    ready_i = 1'b0;
    rd(A_STAT, d); check("after_pop_status", d, 64'h301);

    // Reset with three entries queued; a read in the reset cycle returns 0.
    @(negedge clk_i);
    rst_i = 1'b1;
    reg_valid_i = 1'b1;
    reg_write_i = 1'b0;
    reg_addr_i  = A_STAT;
    #1;
    check("rst_cycle_read", reg_rdata_o, 64'h0);
    @(posedge clk_i); #1;
    reg_valid_i = 1'b0;
    check("rst_flush_valid", 64'(valid_o), 64'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst2_irq", 64'(irq_o), 64'h0);
    rd(A_SRC, d); check("rst2_src", d, 64'h0);
    rd(A_STAT, d); check("rst2_status", d, 64'h0);
    wr(A_NUM, 64'h1_0000_0020);
    rd(A_NUM, d); check("num_truncated", d, 64'h20);
    wr(A_CONF, 64'h3);
    rd(A_CONF, d); check("conf_rw", d, 64'h3);
    rd(A_SUB, d); check("rst2_submit_id", d, 64'h1);
    check("rst2_valid", 64'(valid_o), 64'h1);
    check("rst2_len", 64'(length_o), 64'h20);
    check("rst2_decouple", 64'(decouple_o), 64'h1);
    check("rst2_deburst", 64'(deburst_o), 64'h1);

    // Decode errors and read-only writes.
    reg_acc(1'b0, 7'h48, 64'h0, 1'b0, d, e);
    check("unmapped_err", 64'(e), 64'h1);
    check("unmapped_data", d, 64'h0);
    reg_acc(1'b0, 7'h04, 64'h0, 1'b0, d, e);
    check("misaligned_err", 64'(e), 64'h1);
    reg_acc(1'b1, 7'h09, 64'hdead, 1'b0, d, e);
    check("misaligned_wr_err", 64'(e), 64'h1);
    rd(A_DST, d); check("misaligned_no_write", d, 64'h0);
    reg_acc(1'b1, A_STAT, 64'hffff, 1'b0, d, e);
    check("ro_write_no_err", 64'(e), 64'h0);
    rd(A_STAT, d); check("ro_write_ignored", d, 64'h101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
